tc_timer: RTL and testbench
===========================

# tc_timer

Programmable 32-bit down-counting timer: a memory-mapped responder on the CPU data bus behind the bus bridge. Two instances sit in the system map at 0x7F00–0x7F0B (TC0) and 0x7F10–0x7F1B (TC1). The bridge supplies the full data address, a single write strobe and the write word, and routes this block's read word back to the CPU. The block raises an interrupt request when its count expires, in one-shot or auto-reload mode.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- addr  input  32  byte address from the bridge; only addr[3:2] is decoded.
- we  input  1  write strobe; whole-word writes only.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational from the registers.
- irq  output  1  interrupt request, equal to ctrl.IM AND irq_flag.

## Operation
- Register map (addr[3:2]):
  - 00 CTRL: [0] EN, [2:1] MODE, [3] IM; bits [31:4] read 0.
  - 01 PRESET: read/write.
  - 10 COUNT: read-only; writes ignored.
  - 11 reserved: reads 0; writes ignored.
- FSM states: IDLE, LOAD, CNT, INT.
- IDLE: if EN=1, go to LOAD and clear irq_flag. Otherwise stay; count holds.
- LOAD: count <= PRESET, then go to CNT.
- CNT:
  - If EN=0, go to IDLE; count holds its value.
  - Else if count > 1: count <= count − 1.
  - Else (count is 1 or 0): count <= 0, irq_flag <= 1, go to INT.
  - PRESET=0 therefore expires on the first CNT cycle.
- INT, then go to IDLE:
  - MODE=00: clear CTRL.EN; irq_flag stays 1.
  - MODE=01: clear irq_flag; EN stays 1, so the timer auto-reloads.
  - MODE=1x: treated as 00.
- Write collisions:
  - A CPU write to CTRL in the same cycle as INT clearing EN: the CPU write wins.
  - A PRESET write takes effect at the next LOAD only; an in-progress count is unaffected.
- irq_flag is cleared only by reset, by the IDLE→LOAD transition, or in INT under mode 01.

## Timing
- Reset values: ctrl=0, preset=0, count=0, irq_flag=0, state=IDLE; rdata=0 and irq=0.
- Register writes are accepted on the edge where we=1 and take effect next cycle.
- Enable latency:
  - Enabling write accepted at the edge ending cycle 0: cycle 1 is IDLE, cycle 2 is LOAD, cycle 3 reads COUNT=P.
  - COUNT=P−k in cycle 3+k.
  - irq rises in cycle P+3, for P ≥ 1.
- Mode 01: irq is high for exactly one cycle per period; period is P+3 cycles.
- Mode 00: irq stays high until re-enabled (IDLE→LOAD) or until IM is cleared.
- IM only gates the output; irq_flag still sets when IM=0.
- Clearing EN mid-count: one cycle later the state is IDLE and COUNT freezes. Re-enabling reloads from PRESET; there is no resume.
- Reset mid-operation: all state returns to reset values on that edge, regardless of state or we.

## Configuration
- TC_MODE1_EN defined: mode 01 (auto-reload) behaves as above; CTRL[2:1] stores the written value.
- TC_MODE1_EN undefined:
  - CTRL[2:1] is forced to 00 and reads back 0.
  - All timers are one-shot; INT always clears EN.

## Test plan
- Reset, then read all four addresses -> every read is 0; irq=0.
- Write PRESET=5, then write CTRL=0x9 (EN, mode 00, IM) accepted at cycle 0 -> COUNT reads 5,4,3,2,1 in cycles 3–7; irq=1 from cycle 8 and stays; CTRL reads 0x8.
- Mode 01, PRESET=3, CTRL=0xB (TC_MODE1_EN defined) -> irq one-cycle pulses every 6 cycles; CTRL stays 0xB. Same stimulus with the macro undefined -> single expiry; CTRL reads 0x8.
- PRESET=10, start; write CTRL=0 when COUNT=6 -> COUNT freezes at 5; irq=0. Then write CTRL=0x9 -> reload to 10; no resume.
- PRESET=0, CTRL=0x1 (IM=0) -> irq stays 0. Write CTRL=0x8 after expiry -> irq=1, because the flag was set.
- Assert reset while in CNT with COUNT=4 and we=1 writing PRESET -> next cycle all registers read 0 and irq=0.

Source files
------------

// File: rtl/tc_timer.sv
// Memory-mapped 32-bit down-counting timer with interrupt; one-shot or auto-reload.
// Define TC_MODE1_EN to enable auto-reload (mode 01); otherwise every timer is one-shot.
module tc_timer (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

    state_e      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic ctrl_wr, preset_wr;
    logic unused_bits;

    assign ctrl_wr     = we_i && (addr_i[3:2] == 2'b00);
    assign preset_wr   = we_i && (addr_i[3:2] == 2'b01);
    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:4], wdata_i[2:1]};

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        unique case (state_q)
            StIdle: begin
                if (en_q) begin
                    state_d = StLoad;
                    flag_d  = 1'b0;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en_q) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = 32'd0;
                    flag_d  = 1'b1;
                    state_d = StInt;
                end
            end
            StInt: begin
                state_d = StIdle;
                if (mode_q == 2'b01) begin
                    flag_d = 1'b0;
                end else begin
                    en_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // A CPU write to CTRL overrides the EN clear issued by INT in the same cycle.
        if (ctrl_wr) begin
            en_d   = wdata_i[0];
`ifdef TC_MODE1_EN
            mode_d = wdata_i[2:1];
`else
            mode_d = 2'b00;
`endif
            im_d   = wdata_i[3];
        end
        if (preset_wr) begin
            preset_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        unique case (addr_i[3:2])
            2'b00:   rdata_o = {28'd0, im_q, mode_q, en_q};
            2'b01:   rdata_o = preset_q;
            2'b10:   rdata_o = count_q;
            default: rdata_o = 32'd0;
        endcase
    end

    assign irq_o = im_q & flag_q;

endmodule

// File: tb/tb_tc_timer.sv
// Directed self-checking bench for tc_timer; cycle-accurate expectations per step.
module tb_tc_timer;

    localparam logic [31:0] Base   = 32'h0000_7F00;
    localparam logic [3:0]  OCtrl  = 4'h0;
    localparam logic [3:0]  OPre   = 4'h4;
    localparam logic [3:0]  OCnt   = 4'h8;
    localparam logic [3:0]  ORsv   = 4'hC;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        irq_o;

    int checks = 0;
    int failures = 0;

    tc_timer dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .addr_i  (addr_i),
        .we_i    (we_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [3:0] off, input logic [31:0] exp);
        addr_i = Base | {28'd0, off};
        #1;
        chk(tag, rdata_o, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, irq_o}, {31'd0, exp});
    endtask

    // Inputs change mid-cycle (after negedge); returns mid-cycle of the following cycle.
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d);
        addr_i  = Base | {28'd0, off};
        wdata_i = d;
        we_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        we_i    = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        we_i    = 1'b0;
        addr_i  = Base;
        wdata_i = 32'd0;
        tick();
        tick();
        reset_i = 1'b0;

        // Reset state
        chk_rd("rst_ctrl", OCtrl, 32'd0);
        chk_rd("rst_preset", OPre, 32'd0);
        chk_rd("rst_count", OCnt, 32'd0);
        chk_rd("rst_rsv", ORsv, 32'd0);
        chk_irq("rst_irq", 1'b0);

        // COUNT and reserved slot ignore writes
        wr(OCnt, 32'h1234);
        wr(ORsv, 32'hFFFF_FFFF);
        chk_rd("count_ro", OCnt, 32'd0);
        chk_rd("rsv_ro", ORsv, 32'd0);

        // One-shot, PRESET=5
        wr(OPre, 32'd5);
        chk_rd("preset_rb", OPre, 32'd5);
        wr(OCtrl, 32'h9);
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_rd("os_count", OCnt, 32'(5 - k));
            chk_irq("os_irq_low", 1'b0);
            tick();
        end
        chk_irq("os_irq_c8", 1'b1);
        tick();
        chk_irq("os_irq_c9", 1'b1);
        chk_rd("os_ctrl_c9", OCtrl, 32'h8);
        chk_rd("os_count_c9", OCnt, 32'd0);
        tick();
        tick();
        chk_irq("os_irq_hold", 1'b1);

        // Mode 01 request, PRESET=3 (flag still set from previous expiry)
        wr(OPre, 32'd3);
        wr(OCtrl, 32'hB);
        for (int c = 1; c <= 18; c++) begin
`ifdef TC_MODE1_EN
            chk_irq("ar_irq", (c == 1) || (c % 6 == 0));
            if (c % 3 == 0) chk_rd("ar_ctrl", OCtrl, 32'hB);
`else
            chk_irq("os2_irq", (c == 1) || (c >= 6));
            if (c % 3 == 0) chk_rd("os2_ctrl", OCtrl, (c >= 7) ? 32'h8 : 32'h9);
`endif
            tick();
        end
        wr(OCtrl, 32'h0);
        for (int i = 0; i < 4; i++) tick();

        // Disable mid-count, then re-enable reloads
        wr(OPre, 32'd10);
        wr(OCtrl, 32'h9);
        for (int i = 0; i < 6; i++) tick();
        chk_rd("stop_count6", OCnt, 32'd6);
        wr(OCtrl, 32'h0);
        chk_rd("stop_count5", OCnt, 32'd5);
        tick();
        tick();
        tick();
        chk_rd("stop_frozen", OCnt, 32'd5);
        chk_irq("stop_irq", 1'b0);
        wr(OCtrl, 32'h9);
        tick();
        tick();
        chk_rd("reload_c3", OCnt, 32'd10);
        tick();
        chk_rd("reload_c4", OCnt, 32'd9);
        wr(OCtrl, 32'h0);
        for (int i = 0; i < 3; i++) tick();

        // PRESET=0 with IM=0: flag sets silently
        wr(OPre, 32'd0);
        wr(OCtrl, 32'h1);
        for (int c = 1; c <= 6; c++) begin
            chk_irq("masked_irq", 1'b0);
            tick();
        end
        chk_rd("zero_ctrl", OCtrl, 32'h0);
        wr(OCtrl, 32'h8);
        chk_irq("unmask_irq", 1'b1);
        chk_rd("unmask_ctrl", OCtrl, 32'h8);

        // Reset mid-count, colliding with a PRESET write
        wr(OPre, 32'd6);
        wr(OCtrl, 32'h9);
        for (int i = 0; i < 4; i++) tick();
        chk_rd("pre_rst_count", OCnt, 32'd4);
        reset_i = 1'b1;
        addr_i  = Base | {28'd0, OPre};
        wdata_i = 32'h55;
        we_i    = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        we_i    = 1'b0;
        chk_rd("mrst_ctrl", OCtrl, 32'd0);
        chk_rd("mrst_preset", OPre, 32'd0);
        chk_rd("mrst_count", OCnt, 32'd0);
        chk_rd("mrst_rsv", ORsv, 32'd0);
        chk_irq("mrst_irq", 1'b0);
        tick();
        tick();
        chk_rd("mrst_idle", OCnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
